// File: rtl/alu_result_buffer_pkg.sv
// Shared widths, defaults and opcode encodings for the ALU result buffer.
package alu_result_buffer_pkg;

  localparam int DATA_W          = 16;
  localparam int INST_W          = 3;
  localparam int ENTRY_W         = DATA_W + INST_W;
  localparam int ALU_LAT_DEFAULT = 2;

  typedef enum logic [INST_W-1:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_MUL     = 3'd2,
    OP_AND     = 3'd3,
    OP_XOR     = 3'd4,
    OP_ABS     = 3'd5,
    OP_SUBSHL2 = 3'd6,
    OP_NOP     = 3'd7
  } alu_op_e;

  // A FIFO entry keeps the opcode in the upper bits and the raw result below.
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [INST_W-1:0] inst,
                                                    input logic [DATA_W-1:0] data);
    return {inst, data};
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Synchronous FIFO of {opcode, result} entries. A push into a full FIFO is
// accepted only when a pop happens at the same edge; otherwise it is dropped
// and reported on drop_o. The head is gated to zero while empty.
module alu_result_fifo
  import alu_result_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_p_i,
  input  logic                     reset_n_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [ENTRY_W-1:0]       push_entry_i,
  input  logic                     pop_i,
  output logic [ENTRY_W-1:0]       head_entry_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic               push_ok, pop_ok;

  assign full_o       = (count_q == FULL_CNT);
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;
  assign pop_ok       = pop_i && !empty_o;
  assign push_ok      = push_i && (!full_o || pop_ok);
  assign drop_o       = push_i && !push_ok;
  assign head_entry_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next-state pointers and occupancy; clear wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers with asynchronous reset.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; the gated head hides stale contents.
  always_ff @(posedge clk_p_i) begin
    if (push_ok && !clear_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

endmodule

// File: rtl/alu_result_buffer.sv
// Tracks ops in flight through a fixed-latency ALU, captures each result with
// its opcode into a FIFO when it emerges, and tells upstream when to stop
// issuing so that results already committed to the ALU always find room.
module alu_result_buffer
  import alu_result_buffer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = ALU_LAT_DEFAULT
) (
  input  logic                   clk_p_i,
  input  logic                   reset_n_i,
  input  logic                   issue_valid_i,
  input  logic [INST_W-1:0]      issue_inst_i,
  input  logic [DATA_W-1:0]      alu_data_i,
  input  logic                   clear_i,
  input  logic                   out_ready_i,
  output logic                   out_valid_o,
  output logic [DATA_W-1:0]      out_data_o,
  output logic [INST_W-1:0]      out_inst_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   stall_o,
  output logic                   overflow_o
);

  localparam int SUM_W = 8;

  logic [ALU_LAT:1]             valid_q, valid_d;
  logic [ALU_LAT:1][INST_W-1:0] inst_q, inst_d;
  logic                         overflow_q, overflow_d;
  logic [SUM_W-1:0]             inflight;
  logic [ENTRY_W-1:0]           head_entry;
  logic                         fifo_drop;
  logic                         pop;

  assign out_valid_o              = !empty_o;
  assign {out_inst_o, out_data_o} = head_entry;
  assign pop                      = out_valid_o && out_ready_i;
  assign overflow_o               = overflow_q;

  // Stage k holds the op issued k cycles ago; issue during stall is still tracked.
  always_comb begin
    valid_d    = valid_q;
    inst_d     = inst_q;
    valid_d[1] = issue_valid_i;
    inst_d[1]  = issue_inst_i;
    for (int k = 2; k <= ALU_LAT; k++) begin
      valid_d[k] = valid_q[k-1];
      inst_d[k]  = inst_q[k-1];
    end
    if (clear_i) valid_d = '0;
  end

  // Overflow is sticky until clear; a dropped push in the clear cycle does not count.
  always_comb begin
    overflow_d = overflow_q | fifo_drop;
    if (clear_i) overflow_d = 1'b0;
  end

  // Count committed-but-not-yet-captured results for the stall decision.
  always_comb begin
    inflight = '0;
    for (int k = 1; k <= ALU_LAT; k++) inflight = inflight + SUM_W'(valid_q[k]);
  end

  assign stall_o = (SUM_W'(count_o) + inflight) >= SUM_W'(DEPTH);

  // Tracking pipeline and overflow flag registers.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q    <= '0;
      inst_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      overflow_q <= overflow_d;
    end
  end

  alu_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_p_i      (clk_p_i),
    .reset_n_i    (reset_n_i),
    .clear_i      (clear_i),
    .push_i       (valid_q[ALU_LAT]),
    .push_entry_i (pack_entry(inst_q[ALU_LAT], alu_data_i)),
    .pop_i        (pop),
    .head_entry_o (head_entry),
    .count_o      (count_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .drop_o       (fifo_drop)
  );

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: a directed vector table, hand
// sequences for overflow, wrap, clear and reset, then randomized traffic
// compared against a queue-based reference model.
module tb_alu_result_buffer;
  import alu_result_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic        clk_p_i = 1'b0;
  logic        reset_n_i = 1'b1;
  logic        issue_valid_i = 1'b0;
  logic [2:0]  issue_inst_i = 3'd0;
  logic [15:0] alu_data_i;
  logic        clear_i = 1'b0;
  logic        out_ready_i = 1'b0;
  logic        out_valid_o;
  logic [15:0] out_data_o;
  logic [2:0]  out_inst_o;
  logic [2:0]  count_o;
  logic        full_o, empty_o, stall_o, overflow_o;
  logic [15:0] op_a = 16'd0;
  logic [15:0] op_b = 16'd0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  alu_result_buffer #(.DEPTH(DEPTH), .ALU_LAT(LAT)) dut (
    .clk_p_i       (clk_p_i),
    .reset_n_i     (reset_n_i),
    .issue_valid_i (issue_valid_i),
    .issue_inst_i  (issue_inst_i),
    .alu_data_i    (alu_data_i),
    .clear_i       (clear_i),
    .out_ready_i   (out_ready_i),
    .out_valid_o   (out_valid_o),
    .out_data_o    (out_data_o),
    .out_inst_o    (out_inst_o),
    .count_o       (count_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .stall_o       (stall_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk_p_i = ~clk_p_i;

  function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [15:0] r;
    case (op)
      OP_ADD:     r = a + b;
      OP_SUB:     r = a - b;
      OP_MUL:     r = a * b;
      OP_AND:     r = a & b;
      OP_XOR:     r = a ^ b;
      OP_ABS:     r = a[15] ? (~a + 16'd1) : a;
      OP_SUBSHL2: r = (a - b) << 2;
      default:    r = 16'd0;
    endcase
    return r;
  endfunction

  // Stand-in for the registered ALU: result appears LAT edges after the operands.
  logic [15:0] alu_pipe [LAT];
  always @(posedge clk_p_i) begin
    alu_pipe[0] <= alu_ref(issue_inst_i, op_a, op_b);
    for (int k = 1; k < LAT; k++) alu_pipe[k] <= alu_pipe[k-1];
  end
  assign alu_data_i = alu_pipe[LAT-1];

  typedef struct {
    logic [2:0]  inst;
    logic [15:0] data;
  } ent_t;

  typedef struct {
    int          due;
    logic [2:0]  inst;
    logic [15:0] data;
  } fly_t;

  ent_t mq[$];
  fly_t fq[$];
  logic m_ovf = 1'b0;

  typedef struct {
    logic        iss;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        rdy;
    logic        ev;
    logic [15:0] ed;
    logic [2:0]  ei;
    int          ec;
    logic        ef;
    logic        es;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic iss, input logic [2:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic rdy, input logic ev,
                               input logic [15:0] ed, input logic [2:0] ei, input int ec,
                               input logic ef, input logic es);
    vec_t v;
    v.iss = iss; v.op = op; v.a = a; v.b = b; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.ei = ei; v.ec = ec; v.ef = ef; v.es = es;
    return v;
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic iss, input logic [2:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic rdy, input logic clr);
    issue_valid_i = iss;
    issue_inst_i  = op;
    op_a          = a;
    op_b          = b;
    out_ready_i   = rdy;
    clear_i       = clr;
    #1;
  endtask

  task automatic checkModel();
    logic ev;
    ev = (mq.size() != 0);
    checkOutput("out_valid", out_valid_o, ev);
    checkOutput("out_data", out_data_o, ev ? mq[0].data : 16'd0);
    checkOutput("out_inst", out_inst_o, ev ? mq[0].inst : 3'd0);
    checkOutput("count", count_o, mq.size());
    checkOutput("empty", empty_o, mq.size() == 0);
    checkOutput("full", full_o, mq.size() == DEPTH);
    checkOutput("stall", stall_o, (mq.size() + fq.size()) >= DEPTH);
    checkOutput("overflow", overflow_o, m_ovf);
  endtask

  task automatic modelReset();
    mq.delete();
    fq.delete();
    m_ovf = 1'b0;
  endtask

  task automatic advance();
    fly_t f;
    ent_t e;
    if (clear_i) begin
      modelReset();
    end else begin
      if (mq.size() > 0 && out_ready_i) e = mq.pop_front();
      if (fq.size() > 0 && fq[0].due == cyc) begin
        f = fq.pop_front();
        if (mq.size() < DEPTH) mq.push_back('{f.inst, f.data});
        else m_ovf = 1'b1;
      end
      if (issue_valid_i)
        fq.push_back('{cyc + LAT, issue_inst_i, alu_ref(issue_inst_i, op_a, op_b)});
    end
    cyc++;
    @(posedge clk_p_i);
    @(negedge clk_p_i);
  endtask

  task automatic stepCycle(input logic iss, input logic [2:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic rdy, input logic clr);
    applyStimulus(iss, op, a, b, rdy, clr);
    checkModel();
    advance();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, out_valid_o, 0);
    checkOutput({tag, "_data"}, out_data_o, 0);
    checkOutput({tag, "_inst"}, out_inst_o, 0);
    checkOutput({tag, "_count"}, count_o, 0);
    checkOutput({tag, "_empty"}, empty_o, 1);
    checkOutput({tag, "_full"}, full_o, 0);
    checkOutput({tag, "_stall"}, stall_o, 0);
    checkOutput({tag, "_ovf"}, overflow_o, 0);
  endtask

  initial begin
    vec_t v;
    logic iss, mstall;

    // Directed vectors: single ADD, then four ops filling the FIFO and draining in order.
    vecs.push_back(mkv(1, OP_ADD, 16'h0003, 16'h0005, 1, 0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mkv(0, OP_NOP, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mkv(0, OP_NOP, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mkv(0, OP_NOP, 0, 0, 1, 1, 16'h0008, 0, 1, 0, 0));
    vecs.push_back(mkv(0, OP_NOP, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mkv(1, OP_MUL, 16'h0010, 16'h0010, 0, 0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mkv(1, OP_SUB, 16'h0005, 16'h0007, 0, 0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mkv(1, OP_XOR, 16'h00F0, 16'h000F, 0, 0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mkv(1, OP_AND, 16'h00FF, 16'h003C, 0, 1, 16'h0100, 2, 1, 0, 0));
    vecs.push_back(mkv(0, OP_NOP, 0, 0, 0, 1, 16'h0100, 2, 2, 0, 1));
    vecs.push_back(mkv(0, OP_NOP, 0, 0, 0, 1, 16'h0100, 2, 3, 0, 1));
    vecs.push_back(mkv(0, OP_NOP, 0, 0, 0, 1, 16'h0100, 2, 4, 1, 1));
    vecs.push_back(mkv(0, OP_NOP, 0, 0, 1, 1, 16'h0100, 2, 4, 1, 1));
    vecs.push_back(mkv(0, OP_NOP, 0, 0, 1, 1, 16'hFFFE, 1, 3, 0, 0));
    vecs.push_back(mkv(0, OP_NOP, 0, 0, 1, 1, 16'h00FF, 4, 2, 0, 0));
    vecs.push_back(mkv(0, OP_NOP, 0, 0, 1, 1, 16'h003C, 3, 1, 0, 0));
    vecs.push_back(mkv(0, OP_NOP, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0));

    // Reset values
    #2 reset_n_i = 1'b0;
    #1 checkResetOutputs("reset");
    @(negedge clk_p_i);
    @(negedge clk_p_i);
    reset_n_i = 1'b1;
    cyc = 0;

    foreach (vecs[i]) begin
      v = vecs[i];
      applyStimulus(v.iss, v.op, v.a, v.b, v.rdy, 1'b0);
      checkOutput($sformatf("vec%0d_valid", i), out_valid_o, v.ev);
      checkOutput($sformatf("vec%0d_data", i), out_data_o, v.ed);
      checkOutput($sformatf("vec%0d_inst", i), out_inst_o, v.ei);
      checkOutput($sformatf("vec%0d_count", i), count_o, v.ec);
      checkOutput($sformatf("vec%0d_full", i), full_o, v.ef);
      checkOutput($sformatf("vec%0d_stall", i), stall_o, v.es);
      checkModel();
      advance();
    end

    // Overflow: full FIFO, issue ignoring stall, then clear
    for (int i = 0; i < 4; i++) stepCycle(1, OP_ADD, 16'(i), 16'h0100, 0, 0);
    for (int i = 0; i < 2; i++) stepCycle(0, OP_NOP, 0, 0, 0, 0);
    stepCycle(1, OP_ADD, 16'h0001, 16'h0001, 0, 0);
    for (int i = 0; i < 3; i++) stepCycle(0, OP_NOP, 0, 0, 0, 0);
    applyStimulus(0, OP_NOP, 0, 0, 0, 0);
    checkOutput("ovf_set", overflow_o, 1);
    checkOutput("ovf_count", count_o, 4);
    checkOutput("ovf_head", out_data_o, 16'h0100);
    checkModel();
    advance();
    stepCycle(0, OP_NOP, 0, 0, 0, 1);
    applyStimulus(0, OP_NOP, 0, 0, 0, 0);
    checkOutput("clr_ovf", overflow_o, 0);
    checkOutput("clr_empty", empty_o, 1);
    checkModel();
    advance();

    // Full FIFO with simultaneous push/pop across pointer wrap
    for (int i = 0; i < 4; i++) stepCycle(1, OP_ADD, 16'(i), 16'h0200, 0, 0);
    for (int i = 0; i < 2; i++) stepCycle(0, OP_NOP, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, OP_XOR, 16'(k), 16'h0300, k >= 2, 0);
      checkOutput($sformatf("wrap%0d_count", k), count_o, 4);
      checkOutput($sformatf("wrap%0d_ovf", k), overflow_o, 0);
      checkModel();
      advance();
    end
    for (int i = 0; i < 8; i++) stepCycle(0, OP_NOP, 0, 0, 1, 0);

    // Clear with two ops in flight (and an issue in the clear cycle)
    stepCycle(1, OP_ADD, 16'h0007, 16'h0007, 1, 0);
    stepCycle(1, OP_SUB, 16'h0009, 16'h0001, 1, 0);
    stepCycle(1, OP_MUL, 16'h0003, 16'h0003, 1, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, OP_NOP, 0, 0, 1, 0);
      checkResetOutputs($sformatf("postclr%0d", i));
      checkModel();
      advance();
    end

    // Asynchronous reset mid-cycle with two ops in flight
    stepCycle(1, OP_ADD, 16'h0011, 16'h0022, 1, 0);
    stepCycle(1, OP_XOR, 16'h00AA, 16'h0055, 1, 0);
    applyStimulus(0, OP_NOP, 0, 0, 1, 0);
    #2 reset_n_i = 1'b0;
    #1 checkResetOutputs("midrst");
    modelReset();
    @(posedge clk_p_i);
    @(negedge clk_p_i);
    reset_n_i = 1'b1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, OP_NOP, 0, 0, 1, 0);
      checkResetOutputs($sformatf("postrst%0d", i));
      checkModel();
      advance();
    end

    // Randomized traffic, mostly honouring stall, occasionally clearing
    for (int i = 0; i < 400; i++) begin
      mstall = (mq.size() + fq.size()) >= DEPTH;
      iss = ($urandom_range(0, 2) != 0) && (!mstall || $urandom_range(0, 7) == 0);
      stepCycle(iss, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end
    for (int i = 0; i < 8; i++) stepCycle(0, OP_NOP, 0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning result FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter ALU_LAT, default 2, meaning clock edges from ALU operand presentation to registered ALU result.
REQ-003 clk_p_i  input  1  clock; all state updates on rising edge.
REQ-004 reset_n_i  input  1  reset, asynchronous, active-low.
REQ-005 issue_valid_i  input  1  upstream presents a valid operand/instruction set to the ALU this cycle.
REQ-006 issue_inst_i  input  3  opcode presented to the ALU this cycle.
REQ-007 alu_data_i  input  16  registered ALU result (ALU data_o).
REQ-008 clear_i  input  1  synchronous flush of FIFO, in-flight tags and overflow flag.
REQ-009 out_ready_i  input  1  downstream accepts the head entry.
REQ-010 out_valid_o  output  1  head entry valid.
REQ-011 out_data_o  output  16  head result.
REQ-012 out_inst_o  output  3  opcode that produced the head result.
REQ-013 count_o  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-014 full_o / empty_o  output  1 each  count_o==DEPTH / count_o==0.
REQ-015 stall_o  output  1  upstream SHALL NOT issue while high.
REQ-016 overflow_o  output  1  sticky: a result was dropped.

Function
REQ-017 SHALL track issued ops in an ALU_LAT-deep valid/opcode shift pipeline; stage k holds the op issued k cycles earlier.
REQ-018 Capture: when last stage valid, SHALL write {last-stage opcode, alu_data_i} into FIFO at that rising edge; issue at cycle N -> written at end of cycle N+ALU_LAT -> out_valid_o earliest in cycle N+ALU_LAT+1.
REQ-019 Pop SHALL occur on rising edge when out_valid_o && out_ready_i; out_* combinational from head entry, held stable while out_valid_o && !out_ready_i.
REQ-020 Push with FIFO full and no pop in the same cycle: result dropped, FIFO unchanged, overflow_o set at that edge.
REQ-021 Simultaneous push and pop SHALL both succeed at any occupancy including full; count unchanged.
REQ-022 Pointers SHALL wrap modulo DEPTH; FIFO order strictly issue order.
REQ-023 stall_o SHALL equal (count_o + number of valid in-flight stages) >= DEPTH, from registered state only (no path from out_ready_i); honouring stall_o guarantees no overflow.
REQ-024 issue_valid_i while stall_o high SHALL still be tracked (not ignored); the result may overflow per REQ-020.
REQ-025 clear_i SHALL, at the edge, empty FIFO, invalidate all in-flight stages, clear overflow_o; clear_i has priority over push, pop and issue in that cycle.
REQ-026 No arithmetic on result data; 16-bit value passed unmodified.

Reset
REQ-027 reset_n_i low SHALL asynchronously force: pointers and count 0, in-flight valids 0, overflow_o 0.
REQ-028 Reset outputs: out_valid_o 0, out_data_o 0x0000, out_inst_o 3'b000, count_o 0, empty_o 1, full_o 0, stall_o 0, overflow_o 0.
REQ-029 Reset mid-operation SHALL discard all stored and in-flight results; no spurious capture after release.
REQ-030 FIFO storage array need not be reset; out_data_o/out_inst_o SHALL be gated to 0 while empty.

Structure
REQ-031 Shared package SHALL hold ALU data width 16, opcode width 3, ALU_LAT default 2, and opcode constants ADD=0, SUB=1, MUL=2, AND=3, XOR=4, ABS=5, SUBSHL2=6, NOP=7.
REQ-032 One sub-module alu_result_fifo (synchronous FIFO, DEPTH parameter, 19-bit entries); tracking pipeline and stall logic in the top.

Verification
REQ-033 Issue ADD a=0x03 b=0x05 at cycle 0, out_ready_i=1 -> out_valid_o high cycle 3, out_data_o=0x0008, out_inst_o=0, then empty_o=1.
REQ-034 out_ready_i=0, issue MUL 0x10*0x10, SUB 0x05-0x07, XOR 0xF0^0x0F, AND 0xFF&0x3C back-to-back -> stall_o high after 4th issue, full_o=1, then pops give 0x0100, 0xFFFE, 0x00FF, 0x003C in order.
REQ-035 Full FIFO, out_ready_i=0, ignore stall_o and issue ADD 1+1 -> overflow_o=1, count_o=4, contents unchanged; clear_i -> overflow_o=0, empty_o=1.
REQ-036 Full FIFO, out_ready_i=1 held, continuous issues -> push/pop same cycles, count_o stays 4, no overflow, order preserved across pointer wrap.
REQ-037 Two ops in flight, assert clear_i (then separately reset_n_i low mid-cycle) -> no results ever appear, all outputs at reset values.
